// File: rtl/line_scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scaler_pkg
// Description : Shared types and colour helpers for the line scaler.
// Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

    localparam int c_CX_W  = 11;
    localparam int c_CY_W  = 10;
    localparam int c_PIX_W = 15;

    typedef enum logic [1:0] {
        OVL_OFF     = 2'd0,
        OVL_REPLACE = 2'd1,
        OVL_BLEND   = 2'd2,
        OVL_KEY     = 2'd3
    } ovl_mode_e;

    function automatic logic [7:0] expand5(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

    // BGR555 in, {R8,G8,B8} out.
    function automatic logic [23:0] expand555(input logic [14:0] c);
        return {expand5(c[4:0]), expand5(c[9:5]), expand5(c[14:10])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_scaler_ovl_mixer.sv
`default_nettype none
// ============================================================================
// Module      : ovl_mixer
// Description : Combinational source/overlay mixer with 555-to-888 expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_mixer
    import scaler_pkg::*;
(
    input  logic [c_PIX_W-1:0] i_src_pix,
    input  logic [c_PIX_W-1:0] i_ovl_pix,
    input  ovl_mode_e          i_mode,
    output logic [23:0]        o_rgb
);

    logic [c_PIX_W-1:0] w_blend;
    logic [c_PIX_W-1:0] w_sel;

    genvar ch;
    generate
        for (ch = 0; ch < 3; ch++) begin : g_blend
            logic [5:0] w_sum;
            assign w_sum = {1'b0, i_src_pix[ch*5 +: 5]} + {1'b0, i_ovl_pix[ch*5 +: 5]};
            assign w_blend[ch*5 +: 5] = w_sum[5:1];
        end
    endgenerate

    always_comb begin
        w_sel = i_src_pix;
        case (i_mode)
            OVL_OFF:     w_sel = i_src_pix;
            OVL_REPLACE: w_sel = i_ovl_pix;
            OVL_BLEND:   w_sel = w_blend;
            OVL_KEY:     w_sel = (i_ovl_pix == '0) ? i_src_pix : i_ovl_pix;
            default:     w_sel = i_src_pix;
        endcase
    end

    assign o_rgb = expand555(w_sel);

endmodule
`default_nettype wire

// File: rtl/line_scaler.sv
`default_nettype none
// ============================================================================
// Module      : line_scaler
// Description : Integer upscaler from a line buffer onto output timing.
// Revision    : 1.0 - initial release
// ============================================================================
module line_scaler
    import scaler_pkg::*;
#(
    parameter int          SRC_W    = 256,
    parameter int          SRC_H    = 224,
    parameter int          SCALE    = 3,
    parameter int          X0       = 256,
    parameter int          Y0       = 24,
    parameter int          BUF_LOG2 = 4,
    parameter logic [23:0] BORDER   = 24'h303030
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [c_CX_W-1:0]                  cx,
    input  logic [c_CY_W-1:0]                  cy,
    output logic [BUF_LOG2+$clog2(SRC_W)-1:0]  buf_addr,
    input  logic [c_PIX_W-1:0]                 buf_rdata,
    input  logic [1:0]                         ovl_mode,
    output logic [7:0]                         overlay_x,
    output logic [7:0]                         overlay_y,
    input  logic [c_PIX_W-1:0]                 overlay_color,
    output logic [23:0]                        rgb,
    output logic                               de,
    output logic                               frame_sync
);

    localparam int                c_SX_W    = $clog2(SRC_W);
    localparam int                c_SY_W    = ($clog2(SRC_H) > BUF_LOG2) ? $clog2(SRC_H) : BUF_LOG2;
    localparam logic [c_CX_W-1:0] c_X_BEG   = c_CX_W'(X0);
    localparam logic [c_CX_W-1:0] c_X_END   = c_CX_W'(X0 + SRC_W * SCALE);
    localparam logic [c_CY_W-1:0] c_Y_BEG   = c_CY_W'(Y0);
    localparam logic [c_CY_W-1:0] c_Y_END   = c_CY_W'(Y0 + SRC_H * SCALE);
    localparam logic [2:0]        c_PH_LAST = 3'(SCALE - 1);

    logic [2:0]        r_hp, w_hp, r_vp, w_vp;
    logic [c_SX_W-1:0] r_sx, w_sx;
    logic [c_SY_W-1:0] r_sy, w_sy;
    logic [7:0]        w_ovl_x, w_ovl_y;
    logic              r_locked;
    logic              w_x_in, w_x_run, w_y_in, w_y_run;
    logic              w_line0, w_frame0, w_lock, w_active, w_fs;
    ovl_mode_e         r_mode1, r_mode2;
    logic              r_act1, r_act2, r_fs1, r_fs2;
    logic [23:0]       w_mix;

    assign w_x_in   = (cx >= c_X_BEG) && (cx < c_X_END);
    assign w_x_run  = (cx >  c_X_BEG) && (cx < c_X_END);
    assign w_y_in   = (cy >= c_Y_BEG) && (cy < c_Y_END);
    assign w_y_run  = (cy >  c_Y_BEG) && (cy < c_Y_END);
    assign w_line0  = (cx == '0);
    assign w_frame0 = w_line0 && (cy == c_Y_BEG);
    // The frame-start sample itself counts as locked so X0==0 shows its first pixel.
    assign w_lock   = r_locked || w_frame0;
    assign w_active = w_lock && w_x_in && w_y_in;
    assign w_fs     = (cx == c_X_BEG) && (cy == c_Y_BEG);

    always_comb begin
        w_hp = r_hp;
        w_sx = r_sx;
        if (cx == c_X_BEG) begin
            w_hp = '0;
            w_sx = '0;
        end else if (w_x_run) begin
            if (r_hp == c_PH_LAST) begin
                w_hp = '0;
                w_sx = r_sx + 1'b1;
            end else begin
                w_hp = r_hp + 3'd1;
            end
        end
    end

    always_comb begin
        w_vp = r_vp;
        w_sy = r_sy;
        if (w_frame0) begin
            w_vp = '0;
            w_sy = '0;
        end else if (w_line0 && w_y_run) begin
            if (r_vp == c_PH_LAST) begin
                w_vp = '0;
                w_sy = r_sy + 1'b1;
            end else begin
                w_vp = r_vp + 3'd1;
            end
        end
    end

    generate
        if (c_SX_W >= 8) begin : g_ovl_x_slice
            assign w_ovl_x = w_sx[7:0];
        end else begin : g_ovl_x_pad
            assign w_ovl_x = {{(8 - c_SX_W){1'b0}}, w_sx};
        end
        if (c_SY_W >= 8) begin : g_ovl_y_slice
            assign w_ovl_y = w_sy[7:0];
        end else begin : g_ovl_y_pad
            assign w_ovl_y = {{(8 - c_SY_W){1'b0}}, w_sy};
        end
    endgenerate

    ovl_mixer u_mixer (
        .i_src_pix (buf_rdata),
        .i_ovl_pix (overlay_color),
        .i_mode    (r_mode2),
        .o_rgb     (w_mix)
    );

    // Stage 1 issues the buffer/overlay reads; stage 2 waits for data; stage 3 is the output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hp       <= '0;
            r_sx       <= '0;
            r_vp       <= '0;
            r_sy       <= '0;
            r_locked   <= 1'b0;
            buf_addr   <= '0;
            overlay_x  <= '0;
            overlay_y  <= '0;
            r_mode1    <= OVL_OFF;
            r_mode2    <= OVL_OFF;
            r_act1     <= 1'b0;
            r_act2     <= 1'b0;
            r_fs1      <= 1'b0;
            r_fs2      <= 1'b0;
            rgb        <= '0;
            de         <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            r_hp       <= w_hp;
            r_sx       <= w_sx;
            r_vp       <= w_vp;
            r_sy       <= w_sy;
            r_locked   <= w_lock;
            buf_addr   <= {w_sy[BUF_LOG2-1:0], w_sx};
            overlay_x  <= w_ovl_x;
            overlay_y  <= w_ovl_y;
            r_mode1    <= ovl_mode_e'(ovl_mode);
            r_mode2    <= r_mode1;
            r_act1     <= w_active;
            r_act2     <= r_act1;
            r_fs1      <= w_fs;
            r_fs2      <= r_fs1;
            rgb        <= r_act2 ? w_mix : BORDER;
            de         <= r_act2;
            frame_sync <= r_fs2;
        end
    end

    always @(posedge clk) begin
        assert ((X0 + SRC_W * SCALE <= 1650) && (Y0 + SRC_H * SCALE <= 750) &&
                (SCALE >= 1) && (SCALE <= 7))
            else $error("line_scaler: geometry parameters out of range");
    end

endmodule
`default_nettype wire
